hist_bin_ram: RTL and testbench
===============================

Name: hist_bin_ram

Overview:
Downstream consumer of the histogram binning stage. It accepts packed histogram packets on an AXI-Stream slave and decodes each one. It writes the 8-bit sample into an internal single-port RAM at address base + count, and gives software/test logic a read-back port, a bulk-clear sequencer and statistics counters.

Parameters:
ADDR_W, 12, RAM address width; RAM depth = 2**ADDR_W
DATA_W, 8, stored sample width
BIN_DEPTH, 32, entries per bin region; legal offsets are 0..BIN_DEPTH-1

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  synchronous active-high reset
s_axis_tdata  in  32  packet {rsvd[31:28], count[27:20], storage_addr[19:8], value[7:0]}
s_axis_tvalid  in  1  packet valid
s_axis_tready  out  1  packet accept
rd_req  in  1  read request
rd_addr  in  ADDR_W  read address
rd_ack  out  1  read request accepted this cycle (combinational)
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data valid, one-cycle pulse
clear_req  in  1  start bulk clear
clear_busy  out  1  clear in progress
wr_count  out  32  packets written to RAM
drop_count  out  16  packets dropped, saturating
fmt_err  out  1  sticky: packet seen with rsvd != 0

Behaviour:
- Interface: one clock, aclk. Reset is synchronous and active-high, on areset.
- Reset values:
  - s_axis_tready=0 while areset is high.
  - rd_ack=0, rd_valid=0, rd_data=0, clear_busy=0, wr_count=0, drop_count=0, fmt_err=0.
  - FSM enters RUN.
  - RAM contents are not reset.
- FSM RUN:
  - s_axis_tready=1.
  - Fire = tvalid & tready.
  - On fire, offset = count. If count < BIN_DEPTH, then RAM[(storage_addr + count) mod 2**ADDR_W] <= value on the same edge, and wr_count++ (wraps at 2**32).
  - If count >= BIN_DEPTH, there is no RAM write and drop_count++, saturating at 0xFFFF. The packet is still accepted.
  - rsvd != 0 sets fmt_err. The packet is still processed normally.
- Throughput: one packet per cycle. A written value is readable via the read port from the next cycle.
- Read port (single-port RAM, write priority):
  - rd_ack = rd_req & RUN & !(fire & write).
  - On rd_ack, rd_data/rd_valid update one cycle later with read-old-data semantics.
  - An unacknowledged rd_req must be held by the requester.
  - A dropped packet does not block reads.
- clear_req in RUN → CLEAR on the next edge.
  - A packet firing in the same cycle is processed first.
  - On entry, wr_count, drop_count and fmt_err are zeroed.
- FSM CLEAR:
  - clear_busy=1, s_axis_tready=0, rd_ack=0.
  - A sweep counter writes 0 to addresses 0..2**ADDR_W-1, one per cycle.
  - After writing the last address → RUN, clear_busy=0 on the next cycle.
  - clear_req during CLEAR is ignored.
- Reset mid-CLEAR: returns to RUN and counters are zeroed. RAM is left partially cleared, which is acceptable.
- An upstream tvalid held during CLEAR is accepted on the first RUN cycle.

Decomposition:
- hist_pkg holds:
  - packet field offsets/widths (COUNT_LSB=20, ADDR_LSB=8, RSVD_LSB=28)
  - ADDR_W, BIN_DEPTH
  - bin base address constants 0x020..0x100
  - state enum {RUN, CLEAR}
- One sub-module, hist_spram: single-port synchronous RAM, write enable, registered read, read-old-data, no reset.

Test Plan:
- Packet 0x003040A5 → RAM[0x043]=0xA5, wr_count=1. Read of 0x043 gives rd_ack=1, then rd_valid=1, rd_data=0xA5 next cycle.
- Packet 0x0201007F (count=0x20) → no write (RAM[0x120] unchanged), drop_count=1, tready stays 1. Repeat 70000× → drop_count=0xFFFF.
- Packet 0x002FFF11 → RAM[0x001]=0x11 (address wrap).
- Read request in the same cycle as a writing fire → rd_ack=0. Next cycle with no fire → rd_ack=1, data valid one cycle later. A dropped-packet cycle → rd_ack=1.
- Fill RAM[0x043]=0xA5, then clear_req → clear_busy=1 for 4096 cycles and tready=0. tvalid held throughout is accepted on the first RUN cycle. Read of 0x043 then gives 0x00. Counters read 0 except packets written after the clear.
- Packet 0x103040A5 → fmt_err=1 and RAM[0x043]=0xA5. areset during CLEAR → next cycle clear_busy=0, tready=1, fmt_err=0.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared definitions for the histogram bin RAM: packet field layout, sizing
// defaults, bin base addresses and the controller state encoding.
package hist_pkg;

    localparam int HIST_ADDR_W    = 12;
    localparam int HIST_DATA_W    = 8;
    localparam int HIST_BIN_DEPTH = 32;

    localparam int RSVD_LSB     = 28;
    localparam int RSVD_W       = 4;
    localparam int COUNT_LSB    = 20;
    localparam int COUNT_W      = 8;
    localparam int ADDR_LSB     = 8;
    localparam int ADDR_FIELD_W = 12;
    localparam int VALUE_LSB    = 0;
    localparam int VALUE_W      = 8;

    localparam logic [ADDR_FIELD_W-1:0] BIN_BASE_FIRST = 12'h020;
    localparam logic [ADDR_FIELD_W-1:0] BIN_BASE_LAST  = 12'h100;

    typedef enum logic {
        RUN,
        CLEAR
    } state_t;

    function automatic logic in_bin(input logic [COUNT_W-1:0] count, input int depth);
        return ({{(32-COUNT_W){1'b0}}, count} < 32'(depth));
    endfunction

endpackage

// File: rtl/hist_spram.sv
// Single-port synchronous RAM with registered, read-old-data output; no reset.
module hist_spram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/hist_bin_ram.sv
// Histogram packet sink: stores each in-range sample at base + count in a
// single-port RAM, with a read-back port, bulk clear sweep and statistics.
module hist_bin_ram
    import hist_pkg::*;
#(
    parameter int ADDR_W    = HIST_ADDR_W,
    parameter int DATA_W    = HIST_DATA_W,
    parameter int BIN_DEPTH = HIST_BIN_DEPTH
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic [31:0]       wr_count,
    output logic [15:0]       drop_count,
    output logic              fmt_err
);

    state_t state, state_nx;

    logic [ADDR_W-1:0]  sweep;
    logic [COUNT_W-1:0] pkt_count;
    logic [ADDR_W-1:0]  pkt_base;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  pkt_value;
    logic [RSVD_W-1:0]  pkt_rsvd;
    logic               fire;
    logic               do_write;
    logic               enter_clear;
    logic               rd_seen;

    logic               ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_q;

    assign pkt_count = s_axis_tdata[COUNT_LSB +: COUNT_W];
    assign pkt_base  = ADDR_W'(s_axis_tdata[ADDR_LSB +: ADDR_FIELD_W]);
    assign pkt_value = DATA_W'(s_axis_tdata[VALUE_LSB +: VALUE_W]);
    assign pkt_rsvd  = s_axis_tdata[RSVD_LSB +: RSVD_W];
    assign wr_addr   = pkt_base + ADDR_W'(pkt_count);

    assign fire        = s_axis_tvalid & s_axis_tready;
    assign do_write    = fire & in_bin(pkt_count, BIN_DEPTH);
    assign enter_clear = (state == RUN) & clear_req;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        s_axis_tready = 1'b0;
        clear_busy    = 1'b0;
        case (state)
            RUN: begin
                s_axis_tready = ~areset;
                if (clear_req) begin
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                clear_busy = 1'b1;
                if (sweep == '1) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    // Packet writes own the single RAM port; reads only get it on idle or drop cycles.
    assign rd_ack = rd_req & (state == RUN) & ~areset & ~do_write;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = rd_addr;
        ram_wdata = pkt_value;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_addr  = sweep;
            ram_wdata = '0;
        end else if (do_write) begin
            ram_we   = 1'b1;
            ram_addr = wr_addr;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset || state == RUN) begin
            sweep <= '0;
        end else begin
            sweep <= sweep + 1'b1;
        end
    end

    // Counter zeroing on clear entry overrides the increment of a same-cycle packet.
    always_ff @(posedge aclk) begin
        if (areset || enter_clear) begin
            wr_count   <= '0;
            drop_count <= '0;
            fmt_err    <= 1'b0;
        end else if (fire) begin
            if (do_write) begin
                wr_count <= wr_count + 32'd1;
            end else if (drop_count != '1) begin
                drop_count <= drop_count + 16'd1;
            end
            if (pkt_rsvd != '0) begin
                fmt_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_valid <= 1'b0;
            rd_seen  <= 1'b0;
        end else begin
            rd_valid <= rd_ack;
            if (rd_ack) begin
                rd_seen <= 1'b1;
            end
        end
    end

    // RAM output is unreset; mask it until the first read after reset.
    assign rd_data = rd_seen ? ram_q : '0;

    hist_spram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (aclk),
        .we    (ram_we),
        .re    (rd_ack),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

endmodule

// File: tb/tb_hist_bin_ram.sv
// Self-checking bench for hist_bin_ram: cycle model of RAM, counters and clear
// sweep, with read results scoreboarded through a queue.
module tb_hist_bin_ram;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        rd_req;
    logic [11:0] rd_addr;
    logic        rd_ack;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        clear_req;
    logic        clear_busy;
    logic [31:0] wr_count;
    logic [15:0] drop_count;
    logic        fmt_err;

    always #5 aclk = ~aclk;

    hist_bin_ram #(
        .ADDR_W    (12),
        .DATA_W    (8),
        .BIN_DEPTH (32)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_ack        (rd_ack),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .clear_req     (clear_req),
        .clear_busy    (clear_busy),
        .wr_count      (wr_count),
        .drop_count    (drop_count),
        .fmt_err       (fmt_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0]  mm [4096];
    logic [7:0]  rd_q [$];
    logic        in_clear  = 1'b0;
    int unsigned sw        = 0;
    logic [31:0] m_wc      = '0;
    logic [15:0] m_dc      = '0;
    logic        m_fe      = 1'b0;
    logic        exp_valid = 1'b0;
    int unsigned busy_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called one time unit after a rising edge with inputs already driven.
    task automatic step();
        logic       exp_tready, fire, wr, exp_ack;
        logic [7:0] cnt;
        logic [11:0] wa;
        #3;
        exp_tready = !areset && !in_clear;
        cnt        = s_axis_tdata[27:20];
        wa         = s_axis_tdata[19:8] + {4'b0, cnt};
        fire       = s_axis_tvalid && exp_tready;
        wr         = fire && (cnt < 8'd32);
        exp_ack    = rd_req && !areset && !in_clear && !wr;
        check("tready", s_axis_tready, exp_tready);
        check("rd_ack", rd_ack, exp_ack);
        if (exp_ack) rd_q.push_back(mm[rd_addr]);
        @(posedge aclk);
        if (areset) begin
            in_clear = 1'b0;
            m_wc = '0;
            m_dc = '0;
            m_fe = 1'b0;
        end else begin
            if (fire) begin
                if (wr) begin
                    mm[wa] = s_axis_tdata[7:0];
                    m_wc   = m_wc + 1;
                end else if (m_dc != 16'hFFFF) begin
                    m_dc = m_dc + 1;
                end
                if (s_axis_tdata[31:28] != 4'h0) m_fe = 1'b1;
            end
            if (in_clear) begin
                mm[sw] = 8'h00;
                if (sw == 4095) in_clear = 1'b0;
                sw++;
            end else if (clear_req) begin
                in_clear = 1'b1;
                sw   = 0;
                m_wc = '0;
                m_dc = '0;
                m_fe = 1'b0;
            end
        end
        exp_valid = exp_ack;
        #1;
        check("rd_valid", rd_valid, exp_valid);
        if (exp_valid) begin
            if (rd_q.size() == 0) check("rd_queue", 0, 1);
            else check("rd_data", rd_data, rd_q.pop_front());
        end
        check("clear_busy", clear_busy, in_clear);
        check("wr_count", wr_count, m_wc);
        check("drop_count", drop_count, m_dc);
        check("fmt_err", fmt_err, m_fe);
    endtask

    task automatic send(input logic [31:0] d);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        step();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic read(input logic [11:0] a);
        rd_req  = 1'b1;
        rd_addr = a;
        step();
        rd_req = 1'b0;
        step();
    endtask

    initial begin
        foreach (mm[i]) mm[i] = 8'h00;
        areset        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        rd_req        = 1'b0;
        rd_addr       = '0;
        clear_req     = 1'b0;
        repeat (2) step();
        check("rd_data_reset", rd_data, 8'h00);
        areset = 1'b0;
        step();

        // Basic write and read-back
        send(32'h003040A5);
        step();
        read(12'h043);

        // Out-of-range count drops; prior contents of 0x120 survive
        send(32'h0101105A);
        send(32'h0201007F);
        read(12'h120);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h0201007F;
        for (int i = 0; i < 65540; i++) step();
        s_axis_tvalid = 1'b0;
        check("drop_saturated", drop_count, 16'hFFFF);

        // Address wrap
        send(32'h002FFF11);
        read(12'h001);

        // Write/read collision, then read on drop cycle
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h00504011;
        rd_req        = 1'b1;
        rd_addr       = 12'h045;
        step();
        s_axis_tvalid = 1'b0;
        step();
        rd_req = 1'b0;
        step();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h0201007F;
        rd_req        = 1'b1;
        rd_addr       = 12'h043;
        step();
        s_axis_tvalid = 1'b0;
        rd_req        = 1'b0;
        step();

        // Bulk clear with upstream tvalid held across it
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        busy_n = clear_busy ? 1 : 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h00506233;
        for (int i = 0; i < 4096; i++) begin
            step();
            if (clear_busy) busy_n++;
        end
        check("busy_cycles", busy_n, 4096);
        step();
        s_axis_tvalid = 1'b0;
        step();
        read(12'h043);
        read(12'h067);

        // Format error flag, then reset in the middle of a clear
        send(32'h103040A5);
        read(12'h043);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (50) step();
        areset = 1'b1;
        step();
        areset = 1'b0;
        check("clear_busy_after_reset", clear_busy, 1'b0);
        check("fmt_err_after_reset", fmt_err, 1'b0);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
